alu_nibble_seq: RTL and testbench
=================================

Name: alu_nibble_seq

Overview:
- Multi-cycle sequencer that drives the 4-bit ALU slice (`alu_4bit`) from the initiator side.
- Accepts one WIDTH-bit operation, issues it to the slice one nibble per cycle (LSB first), and chains carry between cycles through a register.
- Collects the nibble results into a WIDTH-bit result with final carry-out.
- Sits between the datapath controller and a single `alu_4bit` instance; the slice itself is purely combinational.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived localparam, number of issue cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in IDLE or DONE.
- op_a  input  WIDTH  operand A; sampled on accepted start.
- op_b  input  WIDTH  operand B; sampled on accepted start.
- opcode  input  2  00 add, 01 subtract (A-B), 10 AND, 11 OR; sampled on start.
- cin  input  1  carry-in for add; sampled on start; ignored for other ops.
- busy  output  1  high while nibbles are being issued.
- done  output  1  one-cycle pulse; result/cout valid.
- result  output  WIDTH  registered result; holds until the next accepted start.
- cout  output  1  registered final carry; for subtract, 1 means no borrow.
- alu_a  output  4  nibble of A to the slice.
- alu_b  output  4  nibble of B (inverted for subtract) to the slice.
- alu_opcode  output  2  opcode to the slice.
- alu_cin  output  1  carry-in to the slice.
- alu_result  input  4  slice result (combinational).
- alu_cout  input  1  slice carry-out (combinational).

Behaviour:
- Reset: on rst high at a clock edge, all state and outputs clear on the next cycle.
  - busy=0, done=0, result=0, cout=0.
  - alu_a, alu_b, alu_opcode and alu_cin are all 0.
  - State IDLE, nibble index 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN stays in RUN while idx < NIBBLES-1, then goes to DONE after the last nibble.
  - DONE --start--> RUN; otherwise DONE goes to IDLE. DONE lasts exactly one cycle.
- Accepting a start in IDLE or DONE:
  - Latch op_a, op_b, opcode and cin; set idx=0.
  - Carry register := cin for add, 1 for subtract, 0 for AND/OR.
- Start while in RUN is ignored; no queuing.
- Slice drive in RUN (combinational from registers):
  - alu_a = A[4*idx+3:4*idx].
  - alu_b = B nibble for add/AND/OR; ~B nibble for subtract.
  - alu_opcode = 00 for add and subtract (subtract is issued as A + ~B + 1); the latched opcode for AND/OR.
  - alu_cin = carry register for add/subtract; 0 for AND/OR.
- Slice drive outside RUN: all four slice outputs are 0.
- Each RUN cycle:
  - result[4*idx+3:4*idx] := alu_result.
  - Carry register := alu_cout for add/subtract; 0 for AND/OR.
  - idx increments.
- On the last nibble: cout := the final carry, done pulses in the following cycle (the DONE state), and busy drops at that point.
- Timing, with start accepted at edge T:
  - busy is high during cycles T+1 .. T+NIBBLES.
  - done is high during cycle T+NIBBLES+1.
  - Total latency is NIBBLES+1 cycles (5 for WIDTH=16).
- Back-to-back: a start seen during the DONE cycle is accepted, giving zero idle cycles between operations.
- Result update during a run:
  - result updates nibble by nibble while busy.
  - Consumers may only use it when done=1 or afterwards.
  - The previous result is overwritten nibble-wise as the new operation proceeds.
- Reset mid-run aborts the operation: no done pulse, and result/cout clear.

Optional Feature:
- Macro: ALU_NIBBLE_SEQ_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0), registered alongside cout.
  - Add/subtract: ovf = (A[msb] == Beff[msb]) && (result[msb] != A[msb]), where Beff is B for add and ~B for subtract.
  - AND/OR: ovf = 0.
  - Holds until the next accepted start.
- Not defined: no ovf port and no related logic; all other behaviour is identical.

Test Plan:
- WIDTH=16, add: 0x1234 + 0x0FFF, cin=0 -> result=0x2233, cout=0; busy high for 4 cycles; done at start+5.
- Add wrap: 0xFFFF + 0x0001, cin=0 -> result=0x0000, cout=1. Repeat with cin=1 on 0x0000 + 0x0000 -> result=0x0001, cout=0.
- Subtract:
  - 0x0007 - 0x0005 -> 0x0002, cout=1.
  - 0x0005 - 0x0007 -> 0xFFFE, cout=0.
  - Check alu_opcode=00 and alu_cin=1 on the first nibble.
- Logic ops: AND 0xF0F0 & 0xFF00 with cin=1 -> 0xF000, cout=0. OR of the same operands -> 0xFFF0, cout=0. alu_cin stays 0 throughout.
- Start handling:
  - A start pulsed mid-run is ignored (single done, result of the first op).
  - A start in the DONE cycle yields a second done exactly 5 cycles later.
  - rst asserted during the 2nd RUN cycle -> busy=0, result=0, no done.
- With ALU_NIBBLE_SEQ_OVF_EN: 0x7FFF + 0x0001 -> result=0x8000, ovf=1; 0x8000 - 0x0001 -> 0x7FFF, ovf=1; 0x0003 + 0x0004 -> ovf=0.

Source files
------------

// File: rtl/alu_nibble_seq_if.sv
// Nibble-wide bus between the sequencer (master) and the combinational alu_4bit slice (slave).
interface alu_nibble_seq_if;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [1:0] alu_opcode;
   logic       alu_cin;
   logic [3:0] alu_result;
   logic       alu_cout;

   modport master (
      output alu_a, alu_b, alu_opcode, alu_cin,
      input  alu_result, alu_cout
   );

   modport slave (
      input  alu_a, alu_b, alu_opcode, alu_cin,
      output alu_result, alu_cout
   );
endinterface

// File: rtl/alu_nibble_seq.sv
// Issues one WIDTH-bit add/sub/AND/OR to a 4-bit ALU slice one nibble per cycle, LSB first.
// Define ALU_NIBBLE_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module alu_nibble_seq #(
   parameter int WIDTH = 16   // multiple of 4, at least 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [1:0]       opcode,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
`ifdef ALU_NIBBLE_SEQ_OVF_EN
   output logic             ovf,
`endif
   alu_nibble_seq_if.master alu
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;

   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [1:0]       op_reg;
   logic             carry;

   logic             is_arith;
   logic             is_sub;
   logic             last_nib;
   logic [3:0]       a_nib;
   logic [3:0]       b_eff_nib;

   assign is_arith  = ~op_reg[1];
   assign is_sub    = (op_reg == OP_SUB);
   assign last_nib  = (idx == LAST_IDX);
   assign a_nib     = a_reg[4*idx +: 4];
   assign b_eff_nib = is_sub ? ~b_reg[4*idx +: 4] : b_reg[4*idx +: 4];

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

   // Subtract goes to the slice as A + ~B + 1, so the slice only ever sees add for arithmetic.
   always_comb begin
      // NOTE: every output gets a default first so no path can leave it unassigned and infer a latch.
      alu.alu_a      = 4'h0;
      alu.alu_b      = 4'h0;
      alu.alu_opcode = 2'b00;
      alu.alu_cin    = 1'b0;
      if (state == ST_RUN) begin
         alu.alu_a      = a_nib;
         alu.alu_b      = b_eff_nib;
         alu.alu_opcode = is_arith ? OP_ADD : op_reg;
         alu.alu_cin    = is_arith ? carry : 1'b0;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         idx    <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         op_reg <= 2'b00;
         carry  <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            ST_RUN: begin
               result[4*idx +: 4] <= alu.alu_result;
               carry              <= is_arith & alu.alu_cout;
               if (last_nib) begin
                  state <= ST_DONE;
                  idx   <= '0;
                  cout  <= is_arith & alu.alu_cout;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
                  // Signed overflow: operands agree in sign but the result sign differs.
                  ovf   <= is_arith && (a_nib[3] == b_eff_nib[3]) &&
                           (alu.alu_result[3] != a_nib[3]);
`endif
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               // IDLE and DONE both accept a new operation; DONE falls back to IDLE otherwise.
               if (start) begin
                  state  <= ST_RUN;
                  idx    <= '0;
                  a_reg  <= op_a;
                  b_reg  <= op_b;
                  op_reg <= opcode;
                  case (opcode)
                     OP_ADD:  carry <= cin;
                     OP_SUB:  carry <= 1'b1;
                     default: carry <= 1'b0;
                  endcase
               end else begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq: directed and random operations against an arithmetic model.
// Define ALU_NIBBLE_SEQ_OVF_EN to also check the ovf output.
module tb_alu_nibble_seq;
   localparam int WIDTH   = 16;
   localparam int NIBBLES = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [1:0]       opcode;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
   logic             ovf;
`endif

   int errors = 0;
   int checks = 0;

   alu_nibble_seq_if bus ();

   alu_nibble_seq #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op_a   (op_a),
      .op_b   (op_b),
      .opcode (opcode),
      .cin    (cin),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
`ifdef ALU_NIBBLE_SEQ_OVF_EN
      .ovf    (ovf),
`endif
      .alu    (bus.slave)
   );

   always #5 clk = ~clk;

   // Combinational alu_4bit slice
   always_comb begin
      logic [4:0] s;
      s = 5'd0;
      case (bus.alu_opcode)
         2'b00: s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'd0, bus.alu_cin};
         2'b01: s = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {4'd0, bus.alu_cin};
         2'b10: s = {1'b0, bus.alu_a & bus.alu_b};
         default: s = {1'b0, bus.alu_a | bus.alu_b};
      endcase
      bus.alu_result = s[3:0];
      bus.alu_cout   = s[4];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: whole-word arithmetic, returns {ovf, cout, result}
   function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] a, b,
                                                input logic [1:0] op, input logic c);
      longint unsigned s;
      logic [WIDTH-1:0] beff;
      logic [WIDTH-1:0] r;
      logic co, ov;
      beff = (op == 2'b01) ? ~b : b;
      co = 1'b0;
      ov = 1'b0;
      case (op)
         2'b00, 2'b01: begin
            s  = longint'(a) + longint'(beff) + ((op == 2'b01) ? 64'd1 : longint'(c));
            r  = s[WIDTH-1:0];
            co = s[WIDTH];
            ov = (a[WIDTH-1] == beff[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         2'b10:   r = a & b;
         default: r = a | b;
      endcase
      return {ov, co, r};
   endfunction

   // Carry into nibble i: carry out of the low 4*i bits of the whole-word sum
   function automatic logic exp_cin(input logic [WIDTH-1:0] a, b,
                                    input logic [1:0] op, input logic c, input int i);
      longint unsigned mask, s, beff, c0;
      if (op[1]) return 1'b0;
      beff = longint'((op == 2'b01) ? ~b : b);
      c0   = (op == 2'b01) ? 64'd1 : longint'(c);
      mask = (64'd1 << (4 * i)) - 64'd1;
      s    = (longint'(a) & mask) + (beff & mask) + c0;
      return s[4 * i];
   endfunction

   task automatic drive_start(input logic [WIDTH-1:0] a, b, input logic [1:0] op, input logic c);
      op_a   = a;
      op_b   = b;
      opcode = op;
      cin    = c;
      start  = 1'b1;
   endtask

   // Called at a negedge with start already driven; returns at the negedge of the done cycle.
   task automatic check_op(input logic [WIDTH-1:0] a, b, input logic [1:0] op, input logic c,
                           input bit mid_start);
      logic [WIDTH+1:0] exp;
      logic [WIDTH-1:0] beff;
      exp  = ref_op(a, b, op, c);
      beff = (op == 2'b01) ? ~b : b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < NIBBLES; i++) begin
         check("busy_run", busy, 1'b1);
         check("done_run", done, 1'b0);
         check("alu_a", bus.alu_a, a[4*i +: 4]);
         check("alu_b", bus.alu_b, beff[4*i +: 4]);
         check("alu_opcode", bus.alu_opcode, op[1] ? op : 2'b00);
         check("alu_cin", bus.alu_cin, exp_cin(a, b, op, c, i));
         if (mid_start && i == 1) drive_start(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom), 1'b1);
         if (mid_start && i == 2) start = 1'b0;
         if (i < NIBBLES - 1) @(negedge clk);
      end
      @(negedge clk);
      check("done_pulse", done, 1'b1);
      check("busy_done", busy, 1'b0);
      check("result", result, exp[WIDTH-1:0]);
      check("cout", cout, exp[WIDTH]);
`ifdef ALU_NIBBLE_SEQ_OVF_EN
      check("ovf", ovf, exp[WIDTH+1]);
`endif
   endtask

   task automatic check_idle(input logic [WIDTH-1:0] exp_res);
      @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
      check("idle_result", result, exp_res);
   endtask

   task automatic single_op(input logic [WIDTH-1:0] a, b, input logic [1:0] op, input logic c);
      logic [WIDTH+1:0] exp;
      exp = ref_op(a, b, op, c);
      drive_start(a, b, op, c);
      check_op(a, b, op, c, 1'b0);
      check_idle(exp[WIDTH-1:0]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] ra, rb;
      logic [1:0]       rop;
      logic             rc;
      logic [WIDTH+1:0] rexp;

      rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; opcode = 2'b00; cin = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_result", result, 16'h0000);
      check("rst_cout", cout, 1'b0);
      check("rst_alu_a", bus.alu_a, 4'h0);
      check("rst_alu_b", bus.alu_b, 4'h0);
      check("rst_alu_opcode", bus.alu_opcode, 2'b00);
      check("rst_alu_cin", bus.alu_cin, 1'b0);
`ifdef ALU_NIBBLE_SEQ_OVF_EN
      check("rst_ovf", ovf, 1'b0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // Directed: add, wrap, carry-in, subtract, logic ops
      single_op(16'h1234, 16'h0FFF, 2'b00, 1'b0);
      check("add_literal", result, 16'h2233);
      single_op(16'hFFFF, 16'h0001, 2'b00, 1'b0);
      check("wrap_cout", cout, 1'b1);
      single_op(16'h0000, 16'h0000, 2'b00, 1'b1);
      check("cin_literal", result, 16'h0001);
      single_op(16'h0007, 16'h0005, 2'b01, 1'b0);
      check("sub_no_borrow", cout, 1'b1);
      single_op(16'h0005, 16'h0007, 2'b01, 1'b0);
      check("sub_borrow", result, 16'hFFFE);
      single_op(16'hF0F0, 16'hFF00, 2'b10, 1'b1);
      check("and_literal", result, 16'hF000);
      single_op(16'hF0F0, 16'hFF00, 2'b11, 1'b1);
      check("or_literal", result, 16'hFFF0);

      // Overflow corner cases (ovf checked only when the feature is built)
      single_op(16'h7FFF, 16'h0001, 2'b00, 1'b0);
      single_op(16'h8000, 16'h0001, 2'b01, 1'b0);
      single_op(16'h0003, 16'h0004, 2'b00, 1'b0);

      // Start mid-run is ignored
      drive_start(16'h1111, 16'h2222, 2'b00, 1'b0);
      check_op(16'h1111, 16'h2222, 2'b00, 1'b0, 1'b1);
      check_idle(16'h3333);

      // Back-to-back: start during DONE
      drive_start(16'hABCD, 16'h1111, 2'b00, 1'b1);
      check_op(16'hABCD, 16'h1111, 2'b00, 1'b1, 1'b0);
      drive_start(16'h0100, 16'h0200, 2'b01, 1'b0);
      check_op(16'h0100, 16'h0200, 2'b01, 1'b0, 1'b0);
      check_idle(16'hFF00);

      // Reset during the second RUN cycle aborts
      drive_start(16'h5555, 16'h3333, 2'b00, 1'b0);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_result", result, 16'h0000);
      check("abort_cout", cout, 1'b0);
      for (int k = 0; k < NIBBLES + 2; k++) begin
         check("abort_no_done", done, 1'b0);
         @(negedge clk);
      end

      // Random operations, sometimes chained back-to-back
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rop = 2'($urandom); rc = 1'($urandom);
      drive_start(ra, rb, rop, rc);
      for (int n = 0; n < 30; n++) begin
         check_op(ra, rb, rop, rc, 1'b0);
         rexp = ref_op(ra, rb, rop, rc);
         if ($urandom_range(0, 1) == 0) check_idle(rexp[WIDTH-1:0]);
         ra = WIDTH'($urandom); rb = WIDTH'($urandom); rop = 2'($urandom); rc = 1'($urandom);
         drive_start(ra, rb, rop, rc);
      end
      check_op(ra, rb, rop, rc, 1'b0);
      rexp = ref_op(ra, rb, rop, rc);
      check_idle(rexp[WIDTH-1:0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
